// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Access size encodings (byte, half, word, double).
//   - Controller state type.
//   - Helper that returns the number of bytes moved by an access size.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        RMW_RD = 3'd2,
        ST_WR  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // Byte count of an access: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            SZ_D:    n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data steering for the load/store unit.
//   size_i         : access size (SZ_B..SZ_D)
//   uns_i          : 1 = zero-extend loads, 0 = sign-extend
//   load_raw_i     : doubleword read from memory
//   load_ext_o     : low 2^size bytes of load_raw_i, extended to 64 bits
//   store_new_i    : store data (low 2^size bytes are significant)
//   store_old_i    : doubleword currently in memory
//   store_merged_o : new low bytes laid over the old doubleword
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [63:0] load_raw_i,
    output logic [63:0] load_ext_o,
    input  logic [63:0] store_new_i,
    input  logic [63:0] store_old_i,
    output logic [63:0] store_merged_o
);

    logic        sign_s;
    logic [63:0] mask_s;

    // Load path: pick the sign bit of the accessed width, then extend.
    always_comb begin
        sign_s     = 1'b0;
        load_ext_o = load_raw_i;
        case (size_i)
            SZ_B: begin
                sign_s     = ~uns_i & load_raw_i[7];
                load_ext_o = {{56{sign_s}}, load_raw_i[7:0]};
            end
            SZ_H: begin
                sign_s     = ~uns_i & load_raw_i[15];
                load_ext_o = {{48{sign_s}}, load_raw_i[15:0]};
            end
            SZ_W: begin
                sign_s     = ~uns_i & load_raw_i[31];
                load_ext_o = {{32{sign_s}}, load_raw_i[31:0]};
            end
            SZ_D: begin
                sign_s     = 1'b0;
                load_ext_o = load_raw_i;
            end
            default: begin
                sign_s     = 1'b0;
                load_ext_o = load_raw_i;
            end
        endcase
    end

    // Store path: byte mask selects which lanes come from the new data.
    always_comb begin
        mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size_i)
            SZ_B:    mask_s = 64'h0000_0000_0000_00FF;
            SZ_H:    mask_s = 64'h0000_0000_0000_FFFF;
            SZ_W:    mask_s = 64'h0000_0000_FFFF_FFFF;
            SZ_D:    mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
            default: mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        store_merged_o = (store_new_i & mask_s) | (store_old_i & ~mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a byte-addressed 64-bit data memory.
// Accepts one request at a time (valid/ready), answers with a one-cycle
// response pulse. Sub-doubleword stores are done as read-modify-write.
//   clk, reset_n        : clock, asynchronous active-low reset
//   req_*               : request from the core (valid/ready handshake)
//   resp_valid/rdata/err: completion pulse, extended load data, fault flag
//   mem_*               : memory port (write commits on falling edge,
//                         read data combinational from mem_addr)
// All outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 64,
    parameter bit          ALIGN_CHECK = 1'b0
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data
);

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    lsu_state_t  state_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [63:0] resp_rdata_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_write_data_q;
    logic        mem_write_q;
    logic        mem_read_q;

    logic        fault_s;
    logic [64:0] end_addr_s;
    logic [63:0] align_mask_s;
    logic [63:0] load_ext_s;
    logic [63:0] store_merged_s;

    // Fault check on the incoming request; the end address is formed in
    // 65 bits so that an address near the top of the space cannot wrap.
    always_comb begin
        end_addr_s   = {1'b0, req_addr} + 65'd8;
        align_mask_s = {60'd0, size_bytes(req_size)} - 64'd1;
        if (end_addr_s > MEM_LIMIT) begin
            fault_s = 1'b1;
        end else if ((ALIGN_CHECK == 1'b1) && ((req_addr & align_mask_s) != 64'd0)) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
    end

    lsu_data_align u_align (
        .size_i         (size_q),
        .uns_i          (uns_q),
        .load_raw_i     (mem_read_data),
        .load_ext_o     (load_ext_s),
        .store_new_i    (wdata_q),
        .store_old_i    (mem_read_data),
        .store_merged_o (store_merged_s)
    );

    // Request controller with registered handshake and memory strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            wdata_q          <= 64'd0;
            req_ready_q      <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 64'd0;
            mem_addr_q       <= 64'd0;
            mem_write_data_q <= 64'd0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata;
                        if (fault_s) begin
                            // Faulting requests never touch the memory port.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 64'd0;
                        end else begin
                            mem_addr_q <= req_addr;
                            if (!req_write) begin
                                state_q    <= LD_RD;
                                mem_read_q <= 1'b1;
                            end else if (req_size == SZ_D) begin
                                state_q          <= ST_WR;
                                mem_write_q      <= 1'b1;
                                mem_write_data_q <= req_wdata;
                            end else begin
                                state_q    <= RMW_RD;
                                mem_read_q <= 1'b1;
                            end
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                LD_RD: begin
                    mem_read_q   <= 1'b0;
                    resp_rdata_q <= load_ext_s;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RMW_RD: begin
                    mem_read_q       <= 1'b0;
                    mem_write_q      <= 1'b1;
                    mem_write_data_q <= store_merged_s;
                    state_q          <= ST_WR;
                end
                ST_WR: begin
                    mem_write_q  <= 1'b0;
                    resp_rdata_q <= 64'd0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 64'd0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (MEM_BYTES=64, ALIGN_CHECK=1).
// A byte-array memory sits on the memory port; a separate reference image
// is updated from the access rules and compared against it.
module tb_load_store_unit;

    localparam int MEMB = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
    logic [63:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;

    logic [7:0] mem     [MEMB];
    logic [7:0] ref_mem [MEMB];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEMB), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    // Memory model: combinational read, commit on the falling edge.
    always_comb begin
        mem_read_data = 64'd0;
        for (int i = 0; i < 8; i++)
            if (mem_addr + 64'(i) < 64'(MEMB))
                mem_read_data[8*i +: 8] = mem[int'(mem_addr) + i];
    end

    always @(negedge clk) begin
        if (mem_write === 1'b1)
            for (int i = 0; i < 8; i++)
                if (mem_addr + 64'(i) < 64'(MEMB))
                    mem[int'(mem_addr) + i] = mem_write_data[8*i +: 8];
    end

    // ---------------- reference model ----------------
    function automatic logic exp_fault(input logic [1:0] sz, input logic [63:0] a);
        int n = 1 << sz;
        return (a > 64'(MEMB - 8)) || ((a % 64'(n)) != 64'd0);
    endfunction

    function automatic logic [63:0] exp_load(input logic [1:0] sz, input logic uns, input logic [63:0] a);
        int n = 1 << sz;
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
        if (!uns && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < MEMB; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < MEMB; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
    endtask

    // Drives one request and observes it up to the response (bounded).
    // lat = cycle count from accept edge to resp_valid, 0 when no response arrives.
    // nbad counts protocol violations seen while busy.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat,
                          output int nrd, output int nwr, output int nbad);
        int k = 0;
        rd = 64'd0; er = 1'b0; lat = 0; nrd = 0; nwr = 0; nbad = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_read === 1'b1) nrd++;
            if (mem_write === 1'b1) nwr++;
            if ((mem_read === 1'b1 || mem_write === 1'b1) && mem_addr !== a) nbad++;
            if (mem_read === 1'b1 && mem_write === 1'b1) nbad++;
            if (req_ready !== 1'b0) nbad++;
            if (resp_valid === 1'b1) begin rd = resp_rdata; er = resp_err; lat = c; break; end
        end
        @(negedge clk);
        if (resp_valid !== 1'b0) nbad++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_mem();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_err, mem_write, mem_read, resp_rdata, mem_addr, mem_write_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        reset_n = 1'b1; #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b required 0", req_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b required 1", req_ready); end
        // Start a load, then drop reset in the middle of its read cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_addr = 64'd40; req_unsigned = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 64'd40) begin
            n_fail++; $display("FAIL ld_rd_strobe: mem_read=%b addr=%0d required 1/40", mem_read, mem_addr);
        end
        #2 reset_n = 1'b0; #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_err, mem_write, mem_read, resp_rdata, mem_addr, mem_write_data} !== '0) begin
            n_fail++; $display("FAIL reset_async: outputs not cleared immediately, required all 0");
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_load_basic();
        logic [63:0] rd; logic er; int lat, nrd, nwr, nbad;
        clear_mem(); mem[40] = 8'd3; ref_mem[40] = 8'd3;
        run_op(1'b0, 2'b11, 1'b0, 64'd40, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== 64'd3) begin n_fail++; $display("FAIL ld_data: got %h required 3", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_err: got %b required 0", er); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ld_latency: got %0d required 2", lat); end
        n_checks++; if (nrd !== 1 || nwr !== 0 || nbad !== 0) begin
            n_fail++; $display("FAIL ld_strobes: rd=%0d wr=%0d bad=%0d required 1/0/0", nrd, nwr, nbad);
        end
    endtask

    task automatic test_store_byte();
        logic [63:0] rd; logic er; int lat, nrd, nwr, nbad;
        run_op(1'b1, 2'b00, 1'b0, 64'd40, 64'h0000_0000_0000_00FF, rd, er, lat, nrd, nwr, nbad);
        ref_store(2'b00, 64'd40, 64'hFF);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d required 3", lat); end
        n_checks++; if (nrd !== 1 || nwr !== 1 || nbad !== 0 || er !== 1'b0 || rd !== 64'd0) begin
            n_fail++; $display("FAIL sb_strobes: rd=%0d wr=%0d bad=%0d err=%b data=%h required 1/1/0/0/0", nrd, nwr, nbad, er, rd);
        end
        n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL sb_memory: %0d bytes differ, required 0", mem_diff()); end
        run_op(1'b0, 2'b00, 1'b0, 64'd40, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL lb_sext: got %h required ffffffffffffffff", rd); end
        run_op(1'b0, 2'b00, 1'b1, 64'd40, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== 64'h0000_0000_0000_00FF) begin n_fail++; $display("FAIL lbu_zext: got %h required ff", rd); end
    endtask

    task automatic test_double_store();
        logic [63:0] rd; logic er; int lat, nrd, nwr, nbad;
        run_op(1'b1, 2'b11, 1'b0, 64'd8, 64'h0123_4567_89AB_CDEF, rd, er, lat, nrd, nwr, nbad);
        ref_store(2'b11, 64'd8, 64'h0123_4567_89AB_CDEF);
        n_checks++; if (lat !== 2 || nrd !== 0 || nwr !== 1) begin
            n_fail++; $display("FAIL sd_timing: lat=%0d rd=%0d wr=%0d required 2/0/1", lat, nrd, nwr);
        end
        run_op(1'b0, 2'b10, 1'b0, 64'd8, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== 64'hFFFF_FFFF_89AB_CDEF) begin n_fail++; $display("FAIL lw_sext: got %h required ffffffff89abcdef", rd); end
        run_op(1'b0, 2'b10, 1'b1, 64'd8, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== 64'h0000_0000_89AB_CDEF) begin n_fail++; $display("FAIL lwu_zext: got %h required 89abcdef", rd); end
        run_op(1'b0, 2'b01, 1'b0, 64'd12, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== 64'h0000_0000_0000_4567) begin n_fail++; $display("FAIL lh_pos: got %h required 4567", rd); end
    endtask

    task automatic test_faults();
        logic [63:0] rd; logic er; int lat, nrd, nwr, nbad;
        run_op(1'b0, 2'b11, 1'b0, 64'd57, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1) begin
            n_fail++; $display("FAIL bounds_fault: err=%b data=%h lat=%0d required 1/0/1", er, rd, lat);
        end
        n_checks++; if (nrd !== 0 || nwr !== 0) begin n_fail++; $display("FAIL bounds_strobes: rd=%0d wr=%0d required 0/0", nrd, nwr); end
        run_op(1'b1, 2'b10, 1'b0, 64'd2, 64'hDEAD_BEEF_CAFE_F00D, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (er !== 1'b1 || nwr !== 0 || nrd !== 0) begin
            n_fail++; $display("FAIL align_fault: err=%b wr=%0d rd=%0d required 1/0/0", er, nwr, nrd);
        end
        n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL align_memory: %0d bytes differ, required 0", mem_diff()); end
        run_op(1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL wrap_fault: got %b required 1", er); end
        run_op(1'b0, 2'b11, 1'b0, 64'd56, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (er !== 1'b0 || rd !== exp_load(2'b11, 1'b0, 64'd56)) begin
            n_fail++; $display("FAIL top_edge_ld: err=%b data=%h required 0/%h", er, rd, exp_load(2'b11, 1'b0, 64'd56));
        end
    endtask

    task automatic test_reset_rmw();
        logic [63:0] rd; logic er; int lat, nrd, nwr, nbad, wseen = 0, rseen = 0;
        mem[16] = 8'h5C; ref_mem[16] = 8'h5C;
        @(negedge clk);
        while (req_ready !== 1'b1 && wseen < 10) begin @(negedge clk); wseen++; end
        wseen = 0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 64'd16; req_wdata = 64'hAA;
        @(posedge clk); #1; req_valid = 1'b0;
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmw_read_phase: mem_read=%b required 1", mem_read); end
        #2 reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write === 1'b1) wseen++;
            if (resp_valid === 1'b1) rseen++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write === 1'b1) wseen++;
            if (resp_valid === 1'b1) rseen++;
        end
        n_checks++; if (wseen !== 0 || rseen !== 0) begin
            n_fail++; $display("FAIL abort_quiet: writes=%0d resps=%0d required 0/0", wseen, rseen);
        end
        n_checks++; if (mem[16] !== 8'h5C) begin n_fail++; $display("FAIL abort_memory: got %h required 5c", mem[16]); end
        run_op(1'b0, 2'b11, 1'b0, 64'd16, 64'd0, rd, er, lat, nrd, nwr, nbad);
        n_checks++; if (rd !== exp_load(2'b11, 1'b0, 64'd16) || er !== 1'b0 || lat !== 2) begin
            n_fail++; $display("FAIL post_abort_ld: data=%h err=%b lat=%0d required %h/0/2", rd, er, lat, exp_load(2'b11, 1'b0, 64'd16));
        end
    endtask

    task automatic test_random();
        logic w, uns, ef, er; logic [1:0] sz; logic [63:0] a, wd, ev, rd;
        int lat, nrd, nwr, nbad, elat, enrd, enwr;
        for (int t = 0; t < 60; t++) begin
            w = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 66));
            if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {$urandom, $urandom};
            ef = exp_fault(sz, a);
            ev = (ef || w) ? 64'd0 : exp_load(sz, uns, a);
            elat = ef ? 1 : (!w ? 2 : (sz == 2'b11 ? 2 : 3));
            enrd = (!ef && (!w || sz != 2'b11)) ? 1 : 0;
            enwr = (!ef && w) ? 1 : 0;
            run_op(w, sz, uns, a, wd, rd, er, lat, nrd, nwr, nbad);
            if (w && !ef) ref_store(sz, a, wd);
            n_checks++; if (er !== ef || rd !== ev) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: err=%b data=%h required %b/%h (w=%b sz=%0d a=%h)", t, er, rd, ef, ev, w, sz, a);
            end
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", t, lat, elat); end
            n_checks++; if (nrd !== enrd || nwr !== enwr || nbad !== 0) begin
                n_fail++; $display("FAIL rnd_strobes[%0d]: rd=%0d wr=%0d bad=%0d required %0d/%0d/0", t, nrd, nwr, nbad, enrd, enwr);
            end
            n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL rnd_memory[%0d]: %0d bytes differ, required 0", t, mem_diff()); end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_byte();
        test_double_store();
        test_faults();
        test_reset_rmw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
